// File: rtl/motor_speed_sequencer_if.sv
// Command/feedback bundle between the host-side controller and the speed sequencer.
// master drives commands and speed feedback; slave (the sequencer) drives forces and status.
interface motor_speed_sequencer_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear_fault;
  logic [7:0] target;
  logic [7:0] speed_fb;
  logic [7:0] af;
  logic [7:0] bf;
  logic [2:0] state;
  logic       at_speed;
  logic       busy;
  logic       fault;

  modport master (
    output tick, start, stop, clear_fault, target, speed_fb,
    input  af, bf, state, at_speed, busy, fault
  );

  modport slave (
    input  tick, start, stop, clear_fault, target, speed_fb,
    output af, bf, state, at_speed, busy, fault
  );
endinterface

// File: rtl/motor_speed_sequencer.sv
// Closed-loop af/bf sequencer: ramps force on tick toward target speed, with cruise band,
// controlled stop and stall timeout. Optional macro SOFT_STOP_EN ramps bf while stopping.
module motor_speed_sequencer #(
  parameter int STEP    = 10,
  parameter int TOL     = 2,
  parameter int AF_MAX  = 200,
  parameter int BF_MAX  = 200,
  parameter int TIMEOUT = 255
) (
  input logic                     clk,
  input logic                     rst,
  motor_speed_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCEL    = 3'd1,
    S_CRUISE   = 3'd2,
    S_BRAKE    = 3'd3,
    S_STOPPING = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam logic [7:0]        STEP8    = 8'(STEP);
  localparam logic [7:0]        AF_MAX8  = 8'(AF_MAX);
  localparam logic [7:0]        BF_MAX8  = 8'(BF_MAX);
  localparam logic [7:0]        TIMEOUT8 = 8'(TIMEOUT);
  localparam logic signed [8:0] TOL_S    = 9'(TOL);

  state_t     state_q, state_d;
  logic [7:0] af_q, af_d;
  logic [7:0] bf_q, bf_d;
  logic [7:0] cnt_q, cnt_d;
  logic       at_speed_q, busy_q, fault_q;

  logic signed [8:0] err;
  logic              in_band, err_pos, err_neg;
  logic [7:0]        cnt_inc;
  logic              timed_out;

  // 9-bit sum catches the carry so a saturated force can never wrap past 255.
  function automatic logic [7:0] ramp(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, v} + {1'b0, STEP8};
    if (s > {1'b0, lim}) ramp = lim;
    else                 ramp = s[7:0];
  endfunction

  assign err       = $signed({1'b0, bus.target}) - $signed({1'b0, bus.speed_fb});
  assign in_band   = (err <= TOL_S) && (err >= -TOL_S);
  assign err_pos   = !err[8] && !in_band;
  assign err_neg   = err[8] && !in_band;
  assign cnt_inc   = cnt_q + 8'd1;
  assign timed_out = (cnt_inc == TIMEOUT8);

  always_comb begin
    state_d = state_q;
    af_d    = af_q;
    bf_d    = bf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        af_d = 8'd0;
        bf_d = 8'd0;
        if (bus.tick && bus.start && (bus.target != 8'd0)) begin
          cnt_d = 8'd0;
          if (in_band)      state_d = S_CRUISE;
          else if (err_pos) state_d = S_ACCEL;
          else              state_d = S_BRAKE;
        end
      end
      S_ACCEL: begin
        bf_d = 8'd0;
        if (bus.tick) begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            state_d = S_FAULT;
            af_d    = 8'd0;
          end else if (in_band) begin
            state_d = S_CRUISE;
          end else if (err_neg) begin
            state_d = S_BRAKE;
            af_d    = 8'd0;
            cnt_d   = 8'd0;
          end else begin
            af_d = ramp(af_q, AF_MAX8);
          end
        end
      end
      S_CRUISE: begin
        bf_d = 8'd0;
        if (bus.tick) begin
          if (err_pos) begin
            state_d = S_ACCEL;
            cnt_d   = 8'd0;
          end else if (err_neg) begin
            state_d = S_BRAKE;
            af_d    = 8'd0;
            cnt_d   = 8'd0;
          end
        end
      end
      S_BRAKE: begin
        af_d = 8'd0;
        if (bus.tick) begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            state_d = S_FAULT;
            bf_d    = 8'd0;
          end else if (in_band) begin
            state_d = S_CRUISE;
            bf_d    = 8'd0;
          end else if (err_pos) begin
            state_d = S_ACCEL;
            bf_d    = 8'd0;
            cnt_d   = 8'd0;
          end else begin
            bf_d = ramp(bf_q, BF_MAX8);
          end
        end
      end
      S_STOPPING: begin
        af_d = 8'd0;
        if (bus.tick) begin
          if (bus.speed_fb == 8'd0) begin
            state_d = S_IDLE;
            bf_d    = 8'd0;
          end else begin
`ifdef SOFT_STOP_EN
            bf_d = ramp(bf_q, BF_MAX8);
`else
            bf_d = BF_MAX8;
`endif
          end
        end
      end
      S_FAULT: begin
        af_d = 8'd0;
        bf_d = 8'd0;
        if (bus.clear_fault) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        af_d    = 8'd0;
        bf_d    = 8'd0;
      end
    endcase

    // stop overrides whatever the tick decided this cycle, including a timeout.
    if (bus.stop && (state_q == S_ACCEL || state_q == S_CRUISE || state_q == S_BRAKE)) begin
      state_d = S_STOPPING;
      af_d    = 8'd0;
      cnt_d   = cnt_q;
`ifdef SOFT_STOP_EN
      bf_d    = 8'd0;
`else
      bf_d    = BF_MAX8;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      af_q       <= 8'd0;
      bf_q       <= 8'd0;
      cnt_q      <= 8'd0;
      at_speed_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      af_q       <= af_d;
      bf_q       <= bf_d;
      cnt_q      <= cnt_d;
      at_speed_q <= (state_d == S_CRUISE);
      busy_q     <= (state_d != S_IDLE);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign bus.af       = af_q;
  assign bus.bf       = bf_q;
  assign bus.state    = state_q;
  assign bus.at_speed = at_speed_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;

endmodule
